// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: multi-precision add sequencer.
// Drives one shared W-bit ripple adder (outside this block) one slice per
// cycle, LSB slice first, chaining the carry through carry_reg, and
// assembles the N*W-bit result in a registered sum with a start/busy/done
// handshake.
module add_seq_ctrl #(
    parameter int W = 32,
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N*W-1:0]   a,
    input  logic [N*W-1:0]   b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [N*W-1:0]   sum,
    output logic             c_out,
    output logic [W-1:0]     add_a,
    output logic [W-1:0]     add_b,
    output logic             add_cin,
    input  logic [W-1:0]     add_sum,
    input  logic             add_cout
);

    // idx needs at least one bit even when there is a single slice
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [IW-1:0]   idx;
    logic            carry_reg;
    logic [N*W-1:0]  a_reg;
    logic [N*W-1:0]  b_reg;

    // Sequencer FSM: latches operands, steps slices, registers the result and handshake flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum       <= '0;
            c_out     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= c_in;
                        sum       <= '0;
                        idx       <= '0;
                        busy      <= 1'b1;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    // The adder is fed from registers, so its result for slice idx is ready this cycle
                    sum[idx*W +: W] <= add_sum;
                    carry_reg       <= add_cout;
                    if (idx == LAST_IDX) begin
                        c_out <= add_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    // Single-cycle pulse; start is deliberately not looked at here
                    done  <= 1'b0;
                    idx   <= '0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    idx   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Adder operand decode: current slice while running, quiet zeros otherwise
    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_reg[idx*W +: W];
            add_b   = b_reg[idx*W +: W];
            add_cin = carry_reg;
        end
    end

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: directed bench for add_seq_ctrl with a behavioural
// model of the external W-bit ripple adder.
module tb_add_seq_ctrl;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int TW = N * W;

    logic          clk;
    logic          rst;
    logic          start;
    logic [TW-1:0] a;
    logic [TW-1:0] b;
    logic          c_in;
    logic          busy;
    logic          done;
    logic [TW-1:0] sum;
    logic          c_out;
    logic [W-1:0]  add_a;
    logic [W-1:0]  add_b;
    logic          add_cin;
    logic [W-1:0]  add_sum;
    logic          add_cout;

    int n_checks = 0;
    int n_fails  = 0;

    logic [N-1:0] cin_seen;

    add_seq_ctrl #(.W(W), .N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .c_in     (c_in),
        .busy     (busy),
        .done     (done),
        .sum      (sum),
        .c_out    (c_out),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_cin  (add_cin),
        .add_sum  (add_sum),
        .add_cout (add_cout)
    );

    // External Para_Adder model
    always_comb begin
        {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [TW:0] obs, input logic [TW:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits for done with a cycle bound; returns edges taken (or -1 on timeout)
    task automatic wait_done(output int edges);
        edges = -1;
        for (int i = 1; i <= 4 * N + 4; i++) begin
            tick();
            if (done) begin
                edges = i;
                break;
            end
        end
    endtask

    // One full operation; scramble holds start high and randomises a/b during RUN
    task automatic run_op(input logic [TW-1:0] opa, input logic [TW-1:0] opb, input logic cin,
                          input logic [TW-1:0] esum, input logic ecout,
                          input string name, input bit scramble);
        int n;
        int busy_cnt;
        int overlap;
        bit got;
        a = opa; b = opb; c_in = cin; start = 1'b1;
        tick();
        if (!scramble) start = 1'b0;
        check({name, "_accept_busy"}, {{TW{1'b0}}, busy}, 1);
        check({name, "_sum_cleared"}, {1'b0, sum}, 0);
        n = 0; busy_cnt = 0; overlap = 0; got = 1'b0; cin_seen = '0;
        while (n < 4 * N + 4 && !got) begin
            if (busy && n < N) cin_seen[n] = add_cin;
            if (busy) busy_cnt++;
            if (busy && done) overlap++;
            if (scramble) begin
                a = {$urandom, $urandom, $urandom, $urandom};
                b = {$urandom, $urandom, $urandom, $urandom};
                c_in = ~c_in;
            end
            tick();
            n++;
            if (done) got = 1'b1;
        end
        check({name, "_done_seen"}, {{TW{1'b0}}, got}, 1);
        check({name, "_latency"}, TW'(n), TW'(N));
        check({name, "_busy_cycles"}, TW'(busy_cnt), TW'(N));
        check({name, "_busy_at_done"}, {{TW{1'b0}}, busy}, 0);
        check({name, "_overlap"}, TW'(overlap), 0);
        check({name, "_sum"}, {1'b0, sum}, {1'b0, esum});
        check({name, "_c_out"}, {{TW{1'b0}}, c_out}, {{TW{1'b0}}, ecout});
        if (!scramble) begin
            tick();
            check({name, "_done_pulse_end"}, {{TW{1'b0}}, done}, 0);
            check({name, "_sum_held"}, {c_out, sum}, {ecout, esum});
            check({name, "_idle_add_a"}, {{(TW-W+1){1'b0}}, add_a}, 0);
            check({name, "_idle_add_cin"}, {{TW{1'b0}}, add_cin}, 0);
        end
    endtask

    initial begin
        int edges;
        int done_cnt;
        rst = 1'b1; start = 1'b1; a = '0; b = '0; c_in = 1'b0;

        // Reset held two cycles with start asserted
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_busy", {{TW{1'b0}}, busy}, 0);
            check("rst_done", {{TW{1'b0}}, done}, 0);
            check("rst_sum", {c_out, sum}, 0);
            check("rst_adder", {{(TW-2*W){1'b0}}, add_a, add_b, add_cin}, 0);
        end
        rst = 1'b0;
        tick();
        check("post_rst_accept", {{TW{1'b0}}, busy}, 1);
        start = 1'b0;
        wait_done(edges);
        check("post_rst_latency", TW'(edges), TW'(N));
        tick();

        // Basic: 0 + 0 + 1
        run_op('0, '0, 1'b1, 128'h1, 1'b0, "basic", 1'b0);

        // Full ripple through all slices
        run_op({TW{1'b1}}, 128'h1, 1'b0, '0, 1'b1, "ripple", 1'b0);
        check("ripple_slice_cin", {{(TW-N+1){1'b0}}, cin_seen}, 4'b1110);

        // Carry across the slice 0 / slice 1 boundary
        run_op(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'h1, 1'b1,
               128'h0000_0000_0000_0000_0000_0001_0000_0001, 1'b0, "boundary", 1'b0);

        // Each slice's top bits overflow into the next
        run_op({4{32'h8000_0000}}, {4{32'h8000_0000}}, 1'b0,
               128'h0000_0001_0000_0001_0000_0001_0000_0000, 1'b1, "msb_chain", 1'b0);
        check("msb_chain_slice_cin", {{(TW-N+1){1'b0}}, cin_seen}, 4'b1110);

        // Handshake robustness: start held, inputs scrambled during RUN
        run_op({4{32'hAAAA_AAAA}}, {4{32'h5555_5555}}, 1'b0, {TW{1'b1}}, 1'b0, "hold", 1'b1);
        a = 128'h3; b = 128'h4; c_in = 1'b0;
        tick();
        check("hold_done_to_idle_busy", {{TW{1'b0}}, busy}, 0);
        check("hold_single_done", {{TW{1'b0}}, done}, 0);
        tick();
        check("hold_reaccept_in_idle", {{TW{1'b0}}, busy}, 1);
        start = 1'b0;
        wait_done(edges);
        check("hold_second_latency", TW'(edges), TW'(N));
        check("hold_second_sum", {c_out, sum}, 129'h7);
        tick();

        // Abort on the second RUN cycle
        a = {TW{1'b1}}; b = 128'h1; c_in = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {{TW{1'b0}}, busy}, 0);
        check("abort_done", {{TW{1'b0}}, done}, 0);
        check("abort_sum", {c_out, sum}, 0);
        done_cnt = 0;
        for (int i = 0; i < N + 2; i++) begin
            tick();
            if (done || busy) done_cnt++;
        end
        check("abort_no_done", TW'(done_cnt), 0);
        run_op(128'd5, 128'd7, 1'b0, 128'd12, 1'b0, "after_abort", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
Multi-precision add sequencer. It computes an N*W-bit sum by driving one shared W-bit ripple adder (Para_Adder, instantiated outside this block) one slice per cycle, least-significant slice first. Carry is chained between slices through an internal register. A start/busy/done handshake lets a simple upstream controller issue wide additions without a wide combinational adder.

Parameters:
W, 32, slice width; must match the W of the external Para_Adder instance
N, 4, number of slices; operand width is N*W; N >= 1

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous reset, active-high
start  input  1  request a new addition; sampled only in IDLE
a  input  N*W  operand A; latched on the accepted start edge
b  input  N*W  operand B; latched on the accepted start edge
c_in  input  1  carry into slice 0; latched on the accepted start edge
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse; sum and c_out are valid in that cycle
sum  output  N*W  registered result; held until the next accepted start or reset
c_out  output  1  registered carry out of slice N-1
add_a  output  W  to adder a: slice idx of latched A
add_b  output  W  to adder b: slice idx of latched B
add_cin  output  1  to adder c_in: carry register
add_sum  input  W  from adder sum (combinational)
add_cout  input  1  from adder c_out (combinational)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high, and takes priority over every other input.
- Reset values: state=IDLE, idx=0, carry_reg=0, a_reg=0, b_reg=0, sum=0, c_out=0, busy=0, done=0.
- States:
  - IDLE: when start=1, latch a, b and c_in into a_reg, b_reg and carry_reg; clear sum to 0; set idx=0; go to RUN. When start=0, hold all state.
  - RUN: on each edge, write add_sum into sum[idx*W +: W] and set carry_reg <= add_cout. If idx==N-1, set c_out <= add_cout and go to DONE. Otherwise idx <= idx+1.
  - DONE: done=1 for exactly this cycle. The next edge returns to IDLE and sets idx=0.
- Adder drive:
  - In RUN: add_a = a_reg[idx*W +: W], add_b = b_reg[idx*W +: W], add_cin = carry_reg. These are decoded combinationally from registers.
  - Outside RUN: add_a, add_b and add_cin are 0.
- Latency: with start accepted at edge k, RUN covers edges k+1..k+N and done is high in the cycle after edge k+N. Total: N+1 cycles from the start edge to done. For N=1 there is a single RUN cycle.
- busy=1 exactly in RUN. done=1 exactly in DONE. busy and done are never high together.
- start is ignored in RUN and DONE; it is not queued. Changes on a, b and c_in after acceptance have no effect on the result in flight.
- Arithmetic:
  - {c_out, sum} = a + b + c_in, taken modulo 2^(N*W+1) with a and b unsigned.
  - A carry out of slice i enters slice i+1 through carry_reg, with exactly one cycle per slice.
- Index width: idx is max(1, clog2(N)) bits and never exceeds N-1.
- Reset mid-RUN or in DONE: the operation is aborted, all outputs return to their reset values, and no done pulse is produced. A start in the first cycle after reset is accepted normally.
- Result hold: sum and c_out keep their values after DONE until the next accepted start (sum cleared) or rst.

Test Plan:
- Reset: assert rst for 2 cycles with start=1 -> busy=0, done=0, sum=0, c_out=0, add_a/add_b/add_cin=0. The held start is not accepted until rst falls.
- Basic, W=32, N=4: a=0, b=0, c_in=1, start for 1 cycle -> busy high 4 cycles, then done pulses 1 cycle (5th cycle after the start edge). sum=128'h1, c_out=0.
- Full ripple: a=128'hFFFF...FFFF, b=1, c_in=0 -> add_cin=1 on slices 1..3, sum=0, c_out=1.
- Slice-boundary carry: a=128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, b=1, c_in=1 -> sum=128'h1_0000_0001, c_out=0.
- Handshake robustness: hold start=1 and randomise a and b during RUN -> result matches the operands latched at the start edge. Exactly one done pulse, and the next start is accepted only in IDLE.
- Abort: assert rst on the 2nd RUN cycle -> next cycle IDLE, sum=0, no done pulse. A new start with a=5, b=7, c_in=0 gives sum=12, c_out=0 after 5 cycles.
